// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, response/burst codes and slave FSM states
package axi_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDS_WIDTH  = 8;
    localparam int LEN_WIDTH  = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} slv_state_t;
endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4 slave-side channel bundle with master/slave views
interface axi_sram_slave_if;
    import axi_pkg::*;
    logic [IDS_WIDTH-1:0]  AWID_S;
    logic [ADDR_WIDTH-1:0] AWADDR_S;
    logic [LEN_WIDTH-1:0]  AWLEN_S;
    logic [2:0]            AWSIZE_S;
    logic [1:0]            AWBURST_S;
    logic                  AWVALID_S;
    logic                  AWREADY_S;
    logic [DATA_WIDTH-1:0] WDATA_S;
    logic [STRB_WIDTH-1:0] WSTRB_S;
    logic                  WLAST_S;
    logic                  WVALID_S;
    logic                  WREADY_S;
    logic [IDS_WIDTH-1:0]  BID_S;
    logic [1:0]            BRESP_S;
    logic                  BVALID_S;
    logic                  BREADY_S;
    logic [IDS_WIDTH-1:0]  ARID_S;
    logic [ADDR_WIDTH-1:0] ARADDR_S;
    logic [LEN_WIDTH-1:0]  ARLEN_S;
    logic [2:0]            ARSIZE_S;
    logic [1:0]            ARBURST_S;
    logic                  ARVALID_S;
    logic                  ARREADY_S;
    logic [IDS_WIDTH-1:0]  RID_S;
    logic [DATA_WIDTH-1:0] RDATA_S;
    logic [1:0]            RRESP_S;
    logic                  RLAST_S;
    logic                  RVALID_S;
    logic                  RREADY_S;

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );
endinterface

// File: rtl/sram_be_model.sv
// sram_be_model: single-port word memory with byte-enable write and registered read
module sram_be_model #(
    parameter int WORDS = 16384,
    parameter int DW = 32,
    localparam int AW = $clog2(WORDS),
    localparam int BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [BW-1:0] be,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [WORDS];

    // byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < BW; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    // read data only moves on a read strobe so it holds through stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI4 INCR slave in front of a byte-enable SRAM
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int MEM_WORDS = 16384
) (
    input  logic ACLK,
    input  logic ARESETn,
    axi_sram_slave_if.slave bus
);
    localparam int IW = $clog2(MEM_WORDS);

    slv_state_t           state;
    logic [IDS_WIDTH-1:0] id_q;
    logic [IW-1:0]        idx;
    logic [LEN_WIDTH-1:0] len_q, beat;
    logic                 rvalid, rlast, wready, bvalid;
    logic                 aw_hs, ar_hs, w_hs, r_hs, mem_re;
    logic [IW-1:0]        mem_addr;
    logic                 unused_ok;

    assign bus.AWREADY_S = ARESETn && state == IDLE;
    assign bus.ARREADY_S = ARESETn && state == IDLE && !bus.AWVALID_S;
    assign aw_hs = bus.AWVALID_S && bus.AWREADY_S;
    assign ar_hs = bus.ARVALID_S && bus.ARREADY_S;
    assign w_hs  = bus.WVALID_S && wready;
    assign r_hs  = rvalid && bus.RREADY_S;
    assign mem_re = ar_hs || (r_hs && !rlast);
    assign mem_addr = state == IDLE ? bus.ARADDR_S[2 +: IW] : state == RD ? idx + IW'(1) : idx;

    assign bus.WREADY_S = wready;
    assign bus.BVALID_S = bvalid;
    assign bus.BID_S    = id_q;
    assign bus.BRESP_S  = OKAY;
    assign bus.RVALID_S = rvalid;
    assign bus.RLAST_S  = rlast;
    assign bus.RID_S    = id_q;
    assign bus.RRESP_S  = OKAY;
    assign unused_ok = ^{bus.AWSIZE_S, bus.AWBURST_S, bus.ARSIZE_S, bus.ARBURST_S, bus.AWLEN_S,
                         bus.AWADDR_S[ADDR_WIDTH-1:2+IW], bus.AWADDR_S[1:0],
                         bus.ARADDR_S[ADDR_WIDTH-1:2+IW], bus.ARADDR_S[1:0]};

    sram_be_model #(.WORDS(MEM_WORDS), .DW(DATA_WIDTH)) u_mem (
        .clk(ACLK), .rst_n(ARESETn), .addr(mem_addr), .we(w_hs), .be(bus.WSTRB_S),
        .wdata(bus.WDATA_S), .re(mem_re), .rdata(bus.RDATA_S)
    );

    // transaction FSM: latch request, sequence beats, drive registered VALID/READY/LAST
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            id_q <= '0;
            idx <= '0;
            len_q <= '0;
            beat <= '0;
            rvalid <= 1'b0;
            rlast <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (aw_hs) begin
                    id_q <= bus.AWID_S;
                    idx <= bus.AWADDR_S[2 +: IW];
                    wready <= 1'b1;
                    state <= WR;
                end else if (ar_hs) begin
                    id_q <= bus.ARID_S;
                    idx <= bus.ARADDR_S[2 +: IW];
                    len_q <= bus.ARLEN_S;
                    beat <= '0;
                    rvalid <= 1'b1;
                    rlast <= bus.ARLEN_S == '0;
                    state <= RD;
                end
                RD: if (r_hs) begin
                    if (rlast) begin
                        rvalid <= 1'b0;
                        rlast <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                        beat <= beat + LEN_WIDTH'(1);
                        rlast <= beat + LEN_WIDTH'(1) == len_q;
                    end
                end
                WR: if (w_hs) begin
                    idx <= idx + IW'(1);
                    if (bus.WLAST_S) begin
                        wready <= 1'b0;
                        bvalid <= 1'b1;
                        state <= WRESP;
                    end
                end
                WRESP: if (bus.BREADY_S) begin
                    bvalid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized AXI traffic checked against an array memory model
module tb_axi_sram_slave;
    import axi_pkg::*;
    localparam int MEM_WORDS = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave_if bus();
    axi_sram_slave #(.MEM_WORDS(MEM_WORDS)) dut (.ACLK(clk), .ARESETn(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] wd [32];
    logic [3:0]  ws [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // wd/ws hold the beats; nbeats may differ from len+1 to exercise early/late WLAST
    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input int nbeats, input int bstall, input bit gaps, input bit with_ar);
        int base, b, stall;
        bit first;
        base = int'((addr >> 2) % MEM_WORDS);
        @(posedge clk); #1;
        bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = len;
        bus.AWSIZE_S = 3'd2; bus.AWBURST_S = INCR; bus.AWVALID_S = 1'b1;
        if (with_ar) bus.ARVALID_S = 1'b1;
        #1;
        stall = 0;
        while (!bus.AWREADY_S && stall < 50) begin @(posedge clk); #2; stall++; end
        check("aw_ready", bus.AWREADY_S, 1);
        check("aw_gates_ar", bus.ARREADY_S, 0);
        @(posedge clk); #1;
        bus.AWVALID_S = 1'b0;
        b = 0; stall = 0; first = 1;
        while (b < nbeats) begin
            bus.WVALID_S = !(gaps && $urandom_range(0, 3) == 0);
            bus.WDATA_S = wd[b]; bus.WSTRB_S = ws[b]; bus.WLAST_S = (b == nbeats - 1);
            #1;
            if (first) check("wready_lat", bus.WREADY_S, 1);
            first = 0;
            if (bus.WVALID_S && bus.WREADY_S) begin
                for (int l = 0; l < 4; l++)
                    if (ws[b][l]) ref_mem[(base + b) % MEM_WORDS][8*l +: 8] = wd[b][8*l +: 8];
                b++;
            end else if (++stall > 200) begin
                check("w_bound", bus.WREADY_S, 1);
                break;
            end
            @(posedge clk); #1;
        end
        bus.WVALID_S = 1'b0; bus.WLAST_S = 1'b0;
        bus.BREADY_S = (bstall == 0);
        #1;
        check("b_lat", bus.BVALID_S, 1);
        check("bid", bus.BID_S, id);
        check("bresp", bus.BRESP_S, 0);
        for (int i = 1; i <= bstall; i++) begin
            @(posedge clk); #1;
            bus.BREADY_S = (i == bstall);
            #1;
            check("bvalid_hold", bus.BVALID_S, 1);
        end
        @(posedge clk); #1;
        bus.BREADY_S = 1'b0;
        #1;
        check("b_done", bus.BVALID_S, 0);
        check("idle_awready", bus.AWREADY_S, 1);
    endtask

    // assumes the AR handshake happens on the next edge; mode 0 full rate, 1 random, 2 fixed stall pattern
    task automatic r_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int mode, input int abort_at);
        int base, b, cyc;
        bit pat [5] = '{0, 1, 0, 0, 1};
        base = int'((addr >> 2) % MEM_WORDS);
        @(posedge clk); #1;
        bus.ARVALID_S = 1'b0;
        b = 0; cyc = 0;
        while (b <= int'(len) && cyc < 200) begin
            if (b == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_rvalid", bus.RVALID_S, 0);
                check("rst_awready", bus.AWREADY_S, 0);
                break;
            end
            bus.RREADY_S = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (cyc < 5 ? pat[cyc] : 1'b1);
            #1;
            if (cyc == 0 || mode == 0) check("rvalid", bus.RVALID_S, 1);
            if (bus.RVALID_S) begin
                check("rdata", bus.RDATA_S, ref_mem[(base + b) % MEM_WORDS]);
                check("rlast", bus.RLAST_S, 32'(b == int'(len)));
                check("rid", bus.RID_S, id);
                check("rresp", bus.RRESP_S, 0);
                if (bus.RREADY_S) b++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (abort_at < 0) check("r_beats", b, int'(len) + 1);
        bus.RREADY_S = 1'b0;
        #1;
        check("r_done", bus.RVALID_S, 0);
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input int mode, input int abort_at);
        int stall;
        @(posedge clk); #1;
        bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len;
        bus.ARSIZE_S = 3'd2; bus.ARBURST_S = INCR; bus.ARVALID_S = 1'b1;
        #1;
        stall = 0;
        while (!bus.ARREADY_S && stall < 50) begin @(posedge clk); #2; stall++; end
        check("ar_ready", bus.ARREADY_S, 1);
        r_phase(id, addr, len, mode, abort_at);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, n, l;
        bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = '0; bus.AWBURST_S = '0;
        bus.AWVALID_S = 0; bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WLAST_S = 0; bus.WVALID_S = 0;
        bus.BREADY_S = 0; bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARSIZE_S = '0;
        bus.ARBURST_S = '0; bus.ARVALID_S = 0; bus.RREADY_S = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready0", bus.AWREADY_S, 0);
        check("rst_arready0", bus.ARREADY_S, 0);
        check("rst_wready0", bus.WREADY_S, 0);
        check("rst_bvalid0", bus.BVALID_S, 0);
        check("rst_rvalid0", bus.RVALID_S, 0);
        check("rst_rdata0", bus.RDATA_S, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_awready", bus.AWREADY_S, 1);
        check("post_rst_arready", bus.ARREADY_S, 1);

        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(8'h15, 32'h10, 4'd0, 1, 0, 0, 0);
        axi_read(8'h2A, 32'h10, 4'd0, 0, -1);
        axi_read(8'h2B, 32'h10 + MEM_WORDS * 4, 4'd0, 0, -1);

        for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
        axi_write(8'h01, 32'h100, 4'd15, 16, 0, 0, 0);
        axi_read(8'h02, 32'h100, 4'd15, 0, -1);

        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        axi_write(8'h03, 32'h20, 4'd0, 1, 0, 0, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5;
        axi_write(8'h04, 32'h20, 4'd0, 1, 0, 0, 0);
        check("strobe_model", ref_mem[8], 32'h11BB_33DD);
        axi_read(8'h05, 32'h20, 4'd0, 0, -1);

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(8'h06, 32'h200, 4'd3, 4, 5, 0, 0);
        axi_read(8'h07, 32'h200, 4'd3, 2, -1);

        bus.ARID_S = 8'h77; bus.ARADDR_S = 32'h200; bus.ARLEN_S = 4'd3;
        bus.ARSIZE_S = 3'd2; bus.ARBURST_S = INCR;
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        axi_write(8'h66, 32'h204, 4'd0, 1, 0, 0, 1);
        check("ar_after_b", bus.ARREADY_S, 1);
        r_phase(8'h77, 32'h200, 4'd3, 0, -1);

        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(8'h08, 32'h300, 4'd7, 3, 0, 0, 0);
        axi_read(8'h09, 32'h300, 4'd2, 0, -1);
        axi_write(8'h0A, 32'h340, 4'd1, 5, 0, 0, 0);
        axi_read(8'h0B, 32'h340, 4'd4, 0, -1);
        axi_write(8'h0C, (MEM_WORDS - 2) * 4, 4'd3, 4, 0, 0, 0);
        axi_read(8'h0D, (MEM_WORDS - 2) * 4, 4'd3, 0, -1);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            axi_write(8'(k), 32'((1024 + 16 * k) * 4), 4'd15, 16, 0, 1, 0);
        end
        for (int k = 0; k < 30; k++) begin
            w = 1024 + $urandom_range(0, 240);
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                n = l + 1;
                for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
                axi_write(8'($urandom), 32'(w * 4), 4'(l), n, $urandom_range(0, 3), 1, 0);
            end else
                axi_read(8'($urandom), 32'(w * 4), 4'(l), 1, -1);
        end

        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(8'h0E, 32'h400, 4'd7, 8, 0, 0, 0);
        axi_read(8'h0F, 32'h400, 4'd7, 0, 2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_awready", bus.AWREADY_S, 1);
        check("rel_arready", bus.ARREADY_S, 1);
        axi_read(8'h10, 32'h400, 4'd7, 0, -1);
        axi_read(8'h11, 32'h10, 4'd0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
